// File: rtl/bitmanip_scheduler_pkg.sv
// Shared types for the bit-count scheduler: word type, op encoding and
// the per-byte leading/trailing zero helpers used by the datapath.
package bitmanip_scheduler_pkg;

    localparam int BITOP_W   = 2;
    localparam int WORD_BITS = 32;

    typedef logic [WORD_BITS-1:0] word_t;

    typedef enum logic [BITOP_W-1:0] {
        BITOP_CLZ  = 2'b00,
        BITOP_CTZ  = 2'b01,
        BITOP_CPOP = 2'b10,
        BITOP_RSVD = 2'b11
    } bitop_e;

    // Only meaningful for a nonzero byte; the caller handles all-zero bytes.
    function automatic logic [3:0] byte_clz(input logic [7:0] b);
        logic [3:0] n;
        n = 4'd8;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) n = 4'(7 - i);
        end
        return n;
    endfunction

    function automatic logic [3:0] byte_ctz(input logic [7:0] b);
        logic [3:0] n;
        n = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (b[i]) n = 4'(i);
        end
        return n;
    endfunction

endpackage

// File: rtl/bitmanip_scheduler_if.sv
// Request/result bundle between the issue ports, the shared bit-count
// scheduler and the writeback arbiter.
interface bitmanip_scheduler_if #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 5
);
    localparam int PORT_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*2-1:0]       req_op;
    logic [NUM_REQ*32-1:0]      req_operand;
    logic [NUM_REQ*TAG_W-1:0]   req_tag;

    logic                       res_valid;
    logic                       res_ready;
    logic [31:0]                res_data;
    logic [PORT_W-1:0]          res_port;
    logic [TAG_W-1:0]           res_tag;

    modport master (
        output req_valid, req_op, req_operand, req_tag, res_ready,
        input  req_ready, res_valid, res_data, res_port, res_tag
    );

    modport slave (
        input  req_valid, req_op, req_operand, req_tag, res_ready,
        output req_ready, res_valid, res_data, res_port, res_tag
    );
endinterface

// File: rtl/bitmanip_scheduler_bitcount_unit.sv
// Combinational CLZ/CTZ/CPOP datapath built from byte-wise zero counts
// plus a bit popcount; reserved op yields zero.
module bitcount_unit
    import bitmanip_scheduler_pkg::*;
(
    input  bitop_e op_i,
    input  word_t  operand_i,
    output word_t  result_o
);
    localparam int NBYTES = WORD_BITS / 8;

    logic [5:0] clz;
    logic [5:0] ctz;
    logic [5:0] cpop;

    // The most significant nonzero byte decides CLZ, the least significant decides CTZ.
    always_comb begin
        clz  = 6'd32;
        ctz  = 6'd32;
        cpop = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (operand_i[8*k +: 8] != 8'h00)
                clz = 6'(8 * (NBYTES - 1 - k)) + 6'(byte_clz(operand_i[8*k +: 8]));
        end
        for (int k = NBYTES - 1; k >= 0; k--) begin
            if (operand_i[8*k +: 8] != 8'h00)
                ctz = 6'(8 * k) + 6'(byte_ctz(operand_i[8*k +: 8]));
        end
        for (int i = 0; i < WORD_BITS; i++) begin
            cpop = cpop + 6'(operand_i[i]);
        end
    end

    always_comb begin
        result_o = '0;
        case (op_i)
            BITOP_CLZ:  result_o = word_t'(clz);
            BITOP_CTZ:  result_o = word_t'(ctz);
            BITOP_CPOP: result_o = word_t'(cpop);
            default:    result_o = '0;
        endcase
    end

endmodule

// File: rtl/bitmanip_scheduler.sv
// Round-robin shared bit-count unit with a 2-stage elastic pipeline.
// Optional per-port op and stall counters under BITMANIP_PERF_CNT_EN.
module bitmanip_scheduler
    import bitmanip_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
`ifdef BITMANIP_PERF_CNT_EN
    output logic [NUM_REQ*WORD_BITS-1:0]  perf_ops,
    output logic [WORD_BITS-1:0]          perf_stall,
`endif
    bitmanip_scheduler_if.slave           bm
);
    localparam int PORT_W = $clog2(NUM_REQ);
    typedef logic [PORT_W-1:0] port_t;
    typedef logic [TAG_W-1:0]  tag_t;

    logic   s1_valid_q, s1_valid_d;
    bitop_e s1_op_q, s1_op_d;
    word_t  s1_operand_q, s1_operand_d;
    tag_t   s1_tag_q, s1_tag_d;
    port_t  s1_port_q, s1_port_d;

    logic   s2_valid_q, s2_valid_d;
    word_t  s2_data_q, s2_data_d;
    tag_t   s2_tag_q, s2_tag_d;
    port_t  s2_port_q, s2_port_d;

    port_t  rr_ptr_q, rr_ptr_d;

    logic   s2_free, s1_free, grant, gnt_found;
    port_t  gnt_idx;
    word_t  bc_result;

    // A stage can take new data when it is empty or its contents leave this cycle.
    assign s2_free = !s2_valid_q || bm.res_ready;
    assign s1_free = !s1_valid_q || s2_free;
    assign grant   = gnt_found && s1_free && !flush && rst_n;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_found && bm.req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = port_t'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        bm.req_ready = '0;
        if (grant) bm.req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant)
            rr_ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : port_t'(gnt_idx + 1'b1);
    end

    bitcount_unit u_bitcount (
        .op_i      (s1_op_q),
        .operand_i (s1_operand_q),
        .result_o  (bc_result)
    );

    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_op_d      = s1_op_q;
        s1_operand_d = s1_operand_q;
        s1_tag_d     = s1_tag_q;
        s1_port_d    = s1_port_q;
        if (grant) begin
            s1_op_d      = bitop_e'(bm.req_op[gnt_idx*BITOP_W +: BITOP_W]);
            s1_operand_d = bm.req_operand[gnt_idx*WORD_BITS +: WORD_BITS];
            s1_tag_d     = bm.req_tag[gnt_idx*TAG_W +: TAG_W];
            s1_port_d    = gnt_idx;
        end
        if (flush)        s1_valid_d = 1'b0;
        else if (s1_free) s1_valid_d = grant;

        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_tag_d   = s2_tag_q;
        s2_port_d  = s2_port_q;
        if (s2_free && s1_valid_q) begin
            s2_data_d = bc_result;
            s2_tag_d  = s1_tag_q;
            s2_port_d = s1_port_q;
        end
        if (flush)        s2_valid_d = 1'b0;
        else if (s2_free) s2_valid_d = s1_valid_q;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= BITOP_CLZ;
            s1_operand_q <= '0;
            s1_tag_q     <= '0;
            s1_port_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_tag_q     <= '0;
            s2_port_q    <= '0;
            rr_ptr_q     <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_op_q      <= s1_op_d;
            s1_operand_q <= s1_operand_d;
            s1_tag_q     <= s1_tag_d;
            s1_port_q    <= s1_port_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_tag_q     <= s2_tag_d;
            s2_port_q    <= s2_port_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign bm.res_valid = s2_valid_q;
    assign bm.res_data  = s2_data_q;
    assign bm.res_tag   = s2_tag_q;
    assign bm.res_port  = s2_port_q;

`ifdef BITMANIP_PERF_CNT_EN
    logic [NUM_REQ-1:0][WORD_BITS-1:0] perf_ops_q, perf_ops_d;
    word_t                             perf_stall_q, perf_stall_d;

    // Counters survive flush; only reset clears them.
    always_comb begin
        perf_ops_d   = perf_ops_q;
        perf_stall_d = perf_stall_q;
        if (grant) perf_ops_d[gnt_idx] = perf_ops_q[gnt_idx] + 1'b1;
        if (s2_valid_q && !bm.res_ready) perf_stall_d = perf_stall_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_bitmanip_scheduler.sv
// Scoreboard bench for bitmanip_scheduler: directed vectors with hand-computed
// results, a per-port driver and a negedge monitor that checks every result.
module tb_bitmanip_scheduler;
    localparam int NUM_REQ = 2;
    localparam int TAG_W   = 5;

    typedef struct {
        logic [1:0]       op;
        logic [31:0]      operand;
        logic [TAG_W-1:0] tag;
        logic [31:0]      exp;
    } item_t;

    typedef struct {
        logic [31:0]      data;
        int               port;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    bitmanip_scheduler_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bm ();

`ifdef BITMANIP_PERF_CNT_EN
    logic [NUM_REQ*32-1:0] perf_ops;
    logic [31:0]           perf_stall;
`endif

    bitmanip_scheduler #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
`ifdef BITMANIP_PERF_CNT_EN
        .perf_ops   (perf_ops),
        .perf_stall (perf_stall),
`endif
        .bm         (bm)
    );

    always #5 clk = ~clk;

    item_t pq [NUM_REQ][$];
    exp_t  sb [$];
    int    grant_log [$];
    int    grant_cyc [$];
    int    acc_cnt [NUM_REQ];
    int    stall_cnt = 0;
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    last_lat = -1;
    bit    lat_chk_en = 1'b0;

    logic        stall_prev = 1'b0;
    logic [31:0] prev_data;
    logic        prev_port;
    logic [TAG_W-1:0] prev_tag;
    item_t       mon_it;
    exp_t        mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Driver: present the head of each port queue just after the clock edge.
    initial begin
        bm.req_valid   = '0;
        bm.req_op      = '0;
        bm.req_operand = '0;
        bm.req_tag     = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int p = 0; p < NUM_REQ; p++) begin
                if (pq[p].size() > 0) begin
                    bm.req_valid[p]               = 1'b1;
                    bm.req_op[2*p +: 2]           = pq[p][0].op;
                    bm.req_operand[32*p +: 32]    = pq[p][0].operand;
                    bm.req_tag[TAG_W*p +: TAG_W]  = pq[p][0].tag;
                end else begin
                    bm.req_valid[p]               = 1'b0;
                    bm.req_op[2*p +: 2]           = '0;
                    bm.req_operand[32*p +: 32]    = '0;
                    bm.req_tag[TAG_W*p +: TAG_W]  = '0;
                end
            end
        end
    end

    // Monitor: record accepts into the scoreboard, compare every delivered result.
    always @(negedge clk) begin
        for (int p = 0; p < NUM_REQ; p++) begin
            if (bm.req_valid[p] && bm.req_ready[p]) begin
                if (pq[p].size() > 0) begin
                    mon_it = pq[p].pop_front();
                    mon_e.data = mon_it.exp;
                    mon_e.port = p;
                    mon_e.tag  = mon_it.tag;
                    mon_e.cyc  = cyc;
                    sb.push_back(mon_e);
                end
                grant_log.push_back(p);
                grant_cyc.push_back(cyc);
                acc_cnt[p]++;
            end
        end
        if (stall_prev) begin
            check("stable_res_data", bm.res_data, prev_data);
            check("stable_res_port", 32'(bm.res_port), 32'(prev_port));
            check("stable_res_tag", 32'(bm.res_tag), 32'(prev_tag));
        end
        if (bm.res_valid && bm.res_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got tag %0d data 0x%08h, expected no result", bm.res_tag, bm.res_data);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("res_data_tag%0d", mon_e.tag), bm.res_data, mon_e.data);
                check($sformatf("res_port_tag%0d", mon_e.tag), 32'(bm.res_port), 32'(mon_e.port));
                check($sformatf("res_tag_tag%0d", mon_e.tag), 32'(bm.res_tag), 32'(mon_e.tag));
                last_lat = cyc - mon_e.cyc;
                if (lat_chk_en) check($sformatf("latency_tag%0d", mon_e.tag), last_lat, 2);
            end
        end
        stall_prev = bm.res_valid && !bm.res_ready;
        prev_data  = bm.res_data;
        prev_port  = bm.res_port;
        prev_tag   = bm.res_tag;
        if (stall_prev) stall_cnt++;
        if (flush || !rst_n) begin
            sb.delete();
            stall_prev = 1'b0;
        end
        if (!rst_n) begin
            for (int p = 0; p < NUM_REQ; p++) acc_cnt[p] = 0;
            stall_cnt = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int p, input logic [1:0] op, input logic [31:0] v,
                        input int tag, input logic [31:0] exp);
        item_t it;
        it.op      = op;
        it.operand = v;
        it.tag     = TAG_W'(tag);
        it.exp     = exp;
        pq[p].push_back(it);
    endtask

    function automatic int pending();
        int n = sb.size();
        for (int p = 0; p < NUM_REQ; p++) n += pq[p].size();
        return n;
    endfunction

    task automatic wait_drain(input string name);
        int n = 0;
        while (pending() != 0 && n < 200) begin
            step();
            n++;
        end
        check({name, "_drained"}, pending(), 0);
        repeat (3) step();
    endtask

    task automatic check_idle(input string name);
        check({name, "_res_valid"}, 32'(bm.res_valid), 0);
        check({name, "_res_data"}, bm.res_data, 0);
        check({name, "_res_port"}, 32'(bm.res_port), 0);
        check({name, "_res_tag"}, 32'(bm.res_tag), 0);
        check({name, "_req_ready"}, 32'(bm.req_ready), 0);
    endtask

`ifdef BITMANIP_PERF_CNT_EN
    task automatic check_perf(input string name);
        for (int p = 0; p < NUM_REQ; p++)
            check($sformatf("%s_perf_ops%0d", name, p), perf_ops[32*p +: 32], acc_cnt[p]);
        check({name, "_perf_stall"}, perf_stall, stall_cnt);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        flush        = 1'b0;
        bm.res_ready = 1'b1;
        step();
        step();
        check_idle("reset");
`ifdef BITMANIP_PERF_CNT_EN
        check_perf("reset");
`endif
        rst_n = 1'b1;
        step();

        // Test 1: single CLZ, fixed two-cycle latency.
        lat_chk_en = 1'b1;
        push(0, 2'b00, 32'h0001_0000, 1, 32'd15);
        wait_drain("t1");
        check("t1_latency", last_lat, 2);

        // Test 2: edge values on port 1.
        push(1, 2'b01, 32'h0000_0000, 2, 32'd32);
        push(1, 2'b00, 32'h8000_0000, 3, 32'd0);
        push(1, 2'b10, 32'hFFFF_FFFF, 4, 32'd32);
        push(1, 2'b01, 32'h0000_0100, 5, 32'd8);
        push(1, 2'b11, 32'h1234_5678, 6, 32'd0);
        wait_drain("t2");

        // Test 3: both ports busy, strict alternation at one op per cycle.
        grant_log.delete();
        grant_cyc.delete();
        push(0, 2'b00, 32'h0000_00FF,  8, 32'd24);
        push(1, 2'b10, 32'h8000_0001,  9, 32'd2);
        push(0, 2'b01, 32'hF000_0000, 10, 32'd28);
        push(1, 2'b01, 32'h0000_0001, 11, 32'd0);
        push(0, 2'b10, 32'h0F0F_0F0F, 12, 32'd16);
        push(1, 2'b00, 32'h00F0_0000, 13, 32'd8);
        push(0, 2'b00, 32'h0000_0001, 14, 32'd31);
        push(1, 2'b01, 32'h0003_0000, 15, 32'd16);
        wait_drain("t3");
        lat_chk_en = 1'b0;
        check("t3_grant_count", grant_log.size(), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
            check($sformatf("t3_grant%0d_port", i), grant_log[i], i % 2);
            check($sformatf("t3_grant%0d_cycle", i), grant_cyc[i] - grant_cyc[0], i);
        end

        // Test 4: backpressure fills both stages, then release.
        bm.res_ready = 1'b0;
        push(0, 2'b10, 32'h0000_0007, 16, 32'd3);
        push(1, 2'b10, 32'hAAAA_AAAA, 17, 32'd16);
        push(0, 2'b00, 32'h0000_8000, 18, 32'd16);
        push(1, 2'b00, 32'h4000_0000, 19, 32'd1);
        push(0, 2'b01, 32'h0080_0000, 20, 32'd23);
        push(1, 2'b01, 32'h8000_0000, 21, 32'd31);
        repeat (4) step();
        check("t4_req_ready_stalled", 32'(bm.req_ready), 0);
        check("t4_res_valid_stalled", 32'(bm.res_valid), 1);
        check("t4_res_tag_head", 32'(bm.res_tag), 16);
        bm.res_ready = 1'b1;
        wait_drain("t4");
`ifdef BITMANIP_PERF_CNT_EN
        check_perf("t4");
`endif

        // Test 5: flush with both stages full.
        bm.res_ready = 1'b0;
        push(0, 2'b10, 32'h0000_0003, 22, 32'd2);
        push(1, 2'b00, 32'h0000_0001, 23, 32'd31);
        repeat (3) step();
        check("t5_res_valid_before_flush", 32'(bm.res_valid), 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t5_res_valid_after_flush", 32'(bm.res_valid), 0);
        bm.res_ready = 1'b1;
        push(0, 2'b01, 32'h0000_0010, 24, 32'd4);
        wait_drain("t5");

        // Test 6: reset in the middle of a stream.
        push(0, 2'b00, 32'h0000_0400, 25, 32'd21);
        push(1, 2'b00, 32'h0200_0000, 26, 32'd6);
        push(0, 2'b10, 32'h0000_00FF, 27, 32'd8);
        push(1, 2'b10, 32'h1111_1111, 28, 32'd8);
        push(0, 2'b01, 32'h0000_0040, 29, 32'd6);
        push(1, 2'b01, 32'h0000_0200, 30, 32'd9);
        repeat (3) step();
        rst_n        = 1'b0;
        bm.res_ready = 1'b0;
        step();
        check_idle("t6_reset");
`ifdef BITMANIP_PERF_CNT_EN
        check_perf("t6_reset");
`endif
        rst_n        = 1'b1;
        bm.res_ready = 1'b1;
        wait_drain("t6");
`ifdef BITMANIP_PERF_CNT_EN
        check_perf("t6_end");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
